// File: rtl/tiny_nn_pkg.sv
// Shared types and constants for the tiny-nn pin protocol and its host driver.
package tiny_nn_pkg;

   typedef logic [15:0] fp_t;

   localparam logic [3:0] CmdOpConvolve = 4'h1;
   localparam fp_t        FPStdNaN      = 16'h7fc0;
   localparam fp_t        IdleWord      = 16'h0000;

   localparam int unsigned DrainCyclesDefault = 5;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCmd,
      StParams,
      StExec,
      StTerm,
      StDrain,
      StWait
   } state_e;

endpackage

// File: rtl/tiny_nn_result_capture.sv
// Tags every streamed word, delays the tag by the core latency and pairs the
// returned lo/hi bytes into 16-bit results.
module tiny_nn_result_capture
   import tiny_nn_pkg::*;
#(
   parameter int unsigned ResultLatency = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push,
   input  logic [7:0] data,
   output fp_t        result,
   output logic       result_valid,
   output logic       empty
);

   logic [ResultLatency-1:0] stream_line_reg;
   logic [ResultLatency-1:0] phase_line_reg;
   logic                     phase_reg;
   logic [7:0]               lo_reg;
   logic                     out_stream;
   logic                     out_phase;

   assign out_stream = stream_line_reg[ResultLatency-1];
   assign out_phase  = phase_line_reg[ResultLatency-1];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stream_line_reg <= '0;
         phase_line_reg  <= '0;
         phase_reg       <= 1'b0;
         lo_reg          <= '0;
      end else begin
         // Phase rests at 0 outside the window, so the first Exec word is a lo byte.
         phase_reg          <= push ? ~phase_reg : 1'b0;
         stream_line_reg[0] <= push;
         phase_line_reg[0]  <= phase_reg;
         for (int i = 1; i < ResultLatency; i++) begin
            stream_line_reg[i] <= stream_line_reg[i-1];
            phase_line_reg[i]  <= phase_line_reg[i-1];
         end
         if (out_stream && !out_phase) begin
            lo_reg <= data;
         end
      end
   end

   assign result       = {data, lo_reg};
   assign result_valid = out_stream & out_phase;
   assign empty        = ~|stream_line_reg;

endmodule

// File: rtl/tiny_nn_host_driver.sv
// Host-side driver: buffers convolve parameters, streams command/params/values
// to the tiny-nn pins and reassembles the returned byte pairs.
module tiny_nn_host_driver
   import tiny_nn_pkg::*;
#(
   parameter int unsigned NumParams     = 8,
   parameter int unsigned ResultLatency = 4,
   parameter int unsigned DrainCycles   = DrainCyclesDefault
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        job_start_i,
   output logic        job_ready_o,
   input  logic [15:0] param_i,
   input  logic        param_valid_i,
   output logic        param_ready_o,
   input  logic [15:0] val_i,
   input  logic        val_last_i,
   input  logic        val_valid_i,
   output logic        val_ready_o,
   output logic [15:0] result_o,
   output logic        result_valid_o,
   output logic        job_done_o,
   output logic        err_o,
   output logic [15:0] tnn_data_o,
   input  logic [7:0]  tnn_data_i
);

   localparam int unsigned CntMax = (NumParams > DrainCycles) ? NumParams : DrainCycles;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned IdxW   = $clog2(NumParams);

   state_e          state_reg;
   logic [CntW-1:0] cnt_reg;
   logic            err_reg;
   logic            ready_en_reg;
   fp_t             param_rf [NumParams];
   logic            push;
   logic            cap_empty;

   assign push = (state_reg == StExec) || (state_reg == StTerm) || (state_reg == StDrain);

   // Held low through reset so job_ready_o only rises the cycle after release.
   assign job_ready_o   = (state_reg == StIdle) && cap_empty && ready_en_reg;
   assign param_ready_o = (state_reg == StLoad);
   assign val_ready_o   = (state_reg == StExec);
   assign job_done_o    = (state_reg == StWait) && cap_empty;
   assign err_o         = err_reg;

   always_ff @(posedge clk_i) begin
      if ((state_reg == StLoad) && param_valid_i) begin
         param_rf[IdxW'(cnt_reg)] <= param_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg    <= StIdle;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
         ready_en_reg <= 1'b0;
      end else begin
         ready_en_reg <= 1'b1;
         unique case (state_reg)
            StIdle: begin
               if (job_start_i && job_ready_o) begin
                  err_reg   <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= StLoad;
               end
            end
            StLoad: begin
               if (param_valid_i) begin
                  if (cnt_reg == CntW'(NumParams - 1)) begin
                     cnt_reg   <= '0;
                     state_reg <= StCmd;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            StCmd: state_reg <= StParams;
            StParams: begin
               if (cnt_reg == CntW'(NumParams - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= StExec;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            StExec: begin
               // A missing value becomes the terminator itself; no separate Term cycle.
               if (!val_valid_i) begin
                  err_reg   <= 1'b1;
                  state_reg <= StDrain;
               end else if (val_last_i) begin
                  state_reg <= StTerm;
               end
            end
            StTerm: state_reg <= StDrain;
            StDrain: begin
               if (cnt_reg == CntW'(DrainCycles - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= StWait;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            StWait: begin
               if (cap_empty) begin
                  state_reg <= StIdle;
               end
            end
            default: state_reg <= StIdle;
         endcase
      end
   end

   always_comb begin
      tnn_data_o = IdleWord;
      case (state_reg)
         StCmd:    tnn_data_o = {CmdOpConvolve, 12'h000};
         StParams: tnn_data_o = param_rf[IdxW'(cnt_reg)];
         StExec:   tnn_data_o = val_valid_i ? val_i : FPStdNaN;
         StTerm:   tnn_data_o = FPStdNaN;
         default:  tnn_data_o = IdleWord;
      endcase
   end

   tiny_nn_result_capture #(
      .ResultLatency(ResultLatency)
   ) u_capture (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push        (push),
      .data        (tnn_data_i),
      .result      (result_o),
      .result_valid(result_valid_o),
      .empty       (cap_empty)
   );

endmodule

// File: tb/tb_tiny_nn_host_driver.sv
// Bench for tiny_nn_host_driver: logs the pins every cycle and checks each job
// against the expected word stream, byte-pair results and completion timing.
module tb_tiny_nn_host_driver;

   localparam int unsigned L    = 4;
   localparam int unsigned D    = 5;
   localparam int unsigned NP   = 8;
   localparam int          LogN = 4096;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        job_start_i = 1'b0;
   logic        job_ready_o;
   logic [15:0] param_i = '0;
   logic        param_valid_i = 1'b0;
   logic        param_ready_o;
   logic [15:0] val_i = '0;
   logic        val_last_i = 1'b0;
   logic        val_valid_i = 1'b0;
   logic        val_ready_o;
   logic [15:0] result_o;
   logic        result_valid_o;
   logic        job_done_o;
   logic        err_o;
   logic [15:0] tnn_data_o;
   logic [7:0]  tnn_data_i = '0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pair_base = -1;

   logic [15:0] log_data  [LogN];
   logic        log_rv    [LogN];
   logic [15:0] log_res   [LogN];
   logic        log_done  [LogN];
   logic [7:0]  bytes_log [LogN];

   tiny_nn_host_driver #(
      .NumParams(NP),
      .ResultLatency(L),
      .DrainCycles(D)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .job_start_i   (job_start_i),
      .job_ready_o   (job_ready_o),
      .param_i       (param_i),
      .param_valid_i (param_valid_i),
      .param_ready_o (param_ready_o),
      .val_i         (val_i),
      .val_last_i    (val_last_i),
      .val_valid_i   (val_valid_i),
      .val_ready_o   (val_ready_o),
      .result_o      (result_o),
      .result_valid_o(result_valid_o),
      .job_done_o    (job_done_o),
      .err_o         (err_o),
      .tnn_data_o    (tnn_data_o),
      .tnn_data_i    (tnn_data_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cyc < LogN) begin
         log_data[cyc] <= tnn_data_o;
         log_rv[cyc]   <= result_valid_o;
         log_res[cyc]  <= result_o;
         log_done[cyc] <= job_done_o;
      end
   end

   // Core stand-in: random bytes every cycle, or a known ramp at the start of a window.
   initial begin : byte_drv
      logic [7:0] b;
      forever begin
         @(posedge clk);
         #1;
         b = 8'($urandom);
         if (pair_base >= 0 && cyc >= pair_base && cyc < pair_base + 4) b = 8'(17 * (cyc - pair_base + 1));
         tnn_data_i = b;
         if (cyc < LogN) bytes_log[cyc] = b;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bit ok;
      int seen;
      for (int sc = 0; sc < 2; sc++) begin
         if (sc == 1) begin
            step();
            job_start_i = 1'b1;
            ok = 0;
            for (int t = 0; t < 32 && !ok; t++) begin
               @(negedge clk);
               if (job_ready_o) ok = 1;
               step();
            end
            job_start_i = 1'b0;
            param_valid_i = 1'b1;
            for (int k = 0; k < 3; k++) begin
               param_i = 16'($urandom);
               step();
            end
            param_valid_i = 1'b0;
         end
         rst_ni = 1'b0;
         for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) rst_ni = 1'b1;
            @(negedge clk);
            total++;
            if ({tnn_data_o, job_ready_o, result_valid_o, job_done_o, err_o, param_ready_o, val_ready_o} !== 22'd0) begin
               bad++;
               $display("FAIL reset_outputs sc=%0d k=%0d: got data=%h rdy=%b rv=%b done=%b err=%b prdy=%b vrdy=%b want all 0",
                        sc, k, tnn_data_o, job_ready_o, result_valid_o, job_done_o, err_o, param_ready_o, val_ready_o);
            end
         end
         step();
         @(negedge clk);
         total++;
         if (job_ready_o !== 1'b1 || param_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release sc=%0d: got job_ready=%b param_ready=%b want 1 0", sc, job_ready_o, param_ready_o);
         end
         seen = 0;
         for (int t = 0; t < 20; t++) begin
            step();
            @(negedge clk);
            if (result_valid_o === 1'b1 || job_done_o === 1'b1) seen++;
         end
         total++;
         if (seen != 0) begin
            bad++;
            $display("FAIL reset_quiet sc=%0d: got %0d pulses want 0", sc, seen);
         end
         $display("reset scenario %0d complete", sc);
      end
   endtask

   task automatic run_job(input string name, input bit fixed_params, input int nvals, input int uf_idx,
                          input bit stall, input bit pairing, input bit b2b);
      logic [15:0] p [NP];
      logic [15:0] v [$];
      logic [15:0] exp_w [$];
      logic [15:0] exp_res;
      int start_c, acc_c, last_acc, cmd_c, exec_c, nacc, j, win, done_c, nres, off, t;
      bit ok, fin, tog, exp_rv;

      for (int i = 0; i < NP; i++) p[i] = fixed_params ? (16'h3f80 + 16'(i)) : 16'($urandom);
      v = {};
      for (int i = 0; i < nvals; i++) v.push_back(16'($urandom));

      step();
      start_c = cyc;
      job_start_i = 1'b1;
      ok = 0;
      acc_c = -1;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge clk);
         if (job_ready_o) begin
            ok = 1;
            acc_c = cyc;
         end
         step();
      end
      job_start_i = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s start_accept: got no job_ready_o within 64 cycles want accept", name);
         return;
      end
      if (b2b) begin
         total++;
         if (acc_c != start_c) begin
            bad++;
            $display("FAIL %s back_to_back_accept: got cycle %0d want %0d", name, acc_c, start_c);
         end
      end

      nacc = 0;
      t = 0;
      tog = 1'b1;
      last_acc = -1;
      while (nacc < NP && t < 200) begin
         param_valid_i = stall ? tog : 1'b1;
         param_i = p[nacc];
         tog = ~tog;
         @(negedge clk);
         if (t == 0) begin
            total++;
            if (err_o !== 1'b0 || param_ready_o !== 1'b1) begin
               bad++;
               $display("FAIL %s load_entry: got err=%b param_ready=%b want 0 1", name, err_o, param_ready_o);
            end
         end
         if (param_valid_i && param_ready_o) begin
            nacc++;
            last_acc = cyc;
         end
         step();
         t++;
      end
      param_valid_i = 1'b0;
      if (nacc < NP) begin
         total++;
         bad++;
         $display("FAIL %s param_load: got %0d accepts want %0d", name, nacc, NP);
         return;
      end

      cmd_c = last_acc + 1;
      exec_c = cmd_c + 1 + NP;
      if (pairing) pair_base = exec_c + L;

      j = 0;
      fin = 0;
      t = 0;
      while (!fin && t < 200) begin
         if (j == uf_idx) begin
            val_valid_i = 1'b0;
            val_last_i = 1'b0;
         end else begin
            val_valid_i = 1'b1;
            val_i = v[j];
            val_last_i = (j == nvals - 1);
         end
         @(negedge clk);
         if (val_ready_o) begin
            if (val_valid_i) begin
               j++;
               if (val_last_i) fin = 1;
            end else begin
               fin = 1;
            end
         end
         step();
         t++;
      end
      val_valid_i = 1'b0;
      val_last_i = 1'b0;
      win = j + 1 + D;

      done_c = -1;
      t = 0;
      while (done_c < 0 && t < 200) begin
         @(negedge clk);
         if (job_done_o === 1'b1) done_c = cyc;
         else step();
         t++;
      end
      #2;
      total++;
      if (done_c != exec_c + win + L) begin
         bad++;
         $display("FAIL %s job_done_cycle: got %0d want %0d", name, done_c, exec_c + win + L);
         pair_base = -1;
         return;
      end

      exp_w = {};
      exp_w.push_back(16'h1000);
      for (int i = 0; i < NP; i++) exp_w.push_back(p[i]);
      for (int i = 0; i < j; i++) exp_w.push_back(v[i]);
      exp_w.push_back(16'h7fc0);
      for (int i = 0; i < D; i++) exp_w.push_back(16'h0000);

      total++;
      if (log_data[last_acc] !== 16'h0000) begin
         bad++;
         $display("FAIL %s load_word: got %h want 0000", name, log_data[last_acc]);
      end
      for (int i = 0; i < exp_w.size(); i++) begin
         total++;
         if (log_data[cmd_c + i] !== exp_w[i]) begin
            bad++;
            $display("FAIL %s word[%0d]: got %h want %h", name, i, log_data[cmd_c + i], exp_w[i]);
         end
      end
      for (int c = exec_c + win; c <= done_c; c++) begin
         total++;
         if (log_data[c] !== 16'h0000) begin
            bad++;
            $display("FAIL %s wait_word@%0d: got %h want 0000", name, c, log_data[c]);
         end
      end

      nres = 0;
      for (int c = cmd_c; c <= done_c; c++) begin
         off = c - (exec_c + L + 1);
         exp_rv = (off >= 0) && (off % 2 == 0) && (off / 2 < win / 2);
         total++;
         if (log_rv[c] !== exp_rv) begin
            bad++;
            $display("FAIL %s result_valid@%0d: got %b want %b", name, c, log_rv[c], exp_rv);
         end
         if (exp_rv) begin
            exp_res = {bytes_log[c], bytes_log[c-1]};
            total++;
            if (log_res[c] !== exp_res) begin
               bad++;
               $display("FAIL %s result@%0d: got %h want %h", name, c, log_res[c], exp_res);
            end
         end
         if (log_rv[c] === 1'b1) nres++;
         if (c < done_c) begin
            total++;
            if (log_done[c] !== 1'b0) begin
               bad++;
               $display("FAIL %s early_done@%0d: got %b want 0", name, c, log_done[c]);
            end
         end
      end
      total++;
      if (nres != win / 2) begin
         bad++;
         $display("FAIL %s result_count: got %0d want %0d", name, nres, win / 2);
      end
      if (pairing) begin
         total++;
         if (log_res[exec_c + L + 1] !== 16'h2211) begin
            bad++;
            $display("FAIL %s pair0: got %h want 2211", name, log_res[exec_c + L + 1]);
         end
         total++;
         if (log_res[exec_c + L + 3] !== 16'h4433) begin
            bad++;
            $display("FAIL %s pair1: got %h want 4433", name, log_res[exec_c + L + 3]);
         end
      end
      total++;
      if (err_o !== (uf_idx >= 0 ? 1'b1 : 1'b0)) begin
         bad++;
         $display("FAIL %s err_at_done: got %b want %b", name, err_o, (uf_idx >= 0));
      end
      pair_base = -1;
      $display("%s: values=%0d window=%0d results=%0d done_cycle=%0d", name, j, win, nres, done_c);
   endtask

   task automatic test_basic();
      run_job("basic", 1'b1, 4, -1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_pairing();
      run_job("pairing", 1'b0, 4, -1, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_param_stall();
      run_job("param_stall", 1'b0, 5, -1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_underflow();
      run_job("underflow", 1'b0, 6, 2, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         @(negedge clk);
         total++;
         if (err_o !== 1'b1) begin
            bad++;
            $display("FAIL underflow err_sticky k=%0d: got %b want 1", k, err_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_job("odd_window", 1'b0, 3, -1, 1'b0, 1'b0, 1'b0);
      run_job("back_to_back", 1'b0, 2, -1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      int n, uf;
      for (int k = 0; k < 5; k++) begin
         n = $urandom_range(1, 7);
         uf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         run_job($sformatf("random%0d", k), 1'b0, n, uf, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      test_reset();
      test_basic();
      test_pairing();
      test_param_stall();
      test_underflow();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tiny_nn_host_driver.md
# tiny_nn_host_driver

Host-side driver for the tiny-nn 16-bit-in / 8-bit-out pin protocol. It buffers eight convolve parameters, issues the convolve command and parameter words, then streams values and the NaN terminator. It reassembles the returned low/high byte pairs into 16-bit results. It sits between a valid/ready job source (testbench, FPGA fabric or SoC) and the tiny-nn top-level pins.

## Interface
- NumParams, 8, parameter words per convolve job (matches the 4x2 value array).
- ResultLatency, 4, cycles from a word driven on tnn_data_o to its corresponding byte on tnn_data_i; range 1..15.
- DrainCycles, 5, filler words driven after the terminator while the core finishes.
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- job_start_i  in  1  start convolve job; accepted when job_ready_o=1
- job_ready_o  out  1  driver idle and capture pipeline empty
- param_i  in  16  parameter word (fp_t)
- param_valid_i / param_ready_o  in/out  1  parameter handshake
- val_i  in  16  value word (fp_t)
- val_last_i  in  1  marks final value of job
- val_valid_i / val_ready_o  in/out  1  value handshake
- result_o  out  16  reassembled result {hi, lo}
- result_valid_o  out  1  one-cycle pulse per result; no backpressure
- job_done_o  out  1  one-cycle pulse when job fully retired
- err_o  out  1  sticky value-underflow error; cleared on next job_start_i accept
- tnn_data_o  out  16  to tiny-nn data input
- tnn_data_i  in  8  from tiny-nn data output

## Operation
- States: Idle, Load, Cmd, Params, Exec, Term, Drain, Wait.
- Idle:
  - tnn_data_o = IdleWord (16'h0000; opcode nibble 0 is a no-op).
  - job_ready_o=1 only if the capture delay line is empty.
  - On job_start_i accept: clear err_o, go to Load.
- Load:
  - param_ready_o=1; accepts NumParams words at any pacing into a local register file.
  - After the last accept, go to Cmd.
- Cmd: drives {CmdOpConvolve, 12'h000} for one cycle, then goes to Params.
- Params:
  - Drives the stored parameters, index 0 first, one per cycle for NumParams cycles; no gaps.
  - Then goes to Exec.
- Exec:
  - val_ready_o=1; each cycle with val_valid_i drives val_i.
  - Accept with val_last_i: go to Term.
  - val_valid_i=0 (underflow): drive FPStdNaN this cycle, set err_o, go directly to Drain (no Term cycle).
- Term: drives FPStdNaN for one cycle, then goes to Drain.
- Drain: drives IdleWord for DrainCycles cycles, then goes to Wait.
- Wait:
  - Holds IdleWord until the capture delay line is empty.
  - Then pulses job_done_o and returns to Idle.
- Capture:
  - Every cycle in Exec/Term/Drain pushes {stream=1, phase} into a ResultLatency-deep delay line.
  - phase resets to 0 on the first Exec cycle and toggles every cycle.
  - At the delay-line output with stream=1: phase 0 latches tnn_data_i as lo; phase 1 emits result_o={tnn_data_i, lo} with result_valid_o=1.
  - Results per job = floor((N+1+DrainCycles)/2), where N = values accepted. A trailing unpaired lo byte is discarded.
- job_start_i outside Idle is ignored.
- tnn_data_i outside the capture window is ignored.

## Timing
- Reset (rst_ni=0 at a clock edge):
  - State = Idle; delay line cleared.
  - Outputs: tnn_data_o=16'h0000; job_ready_o, result_valid_o, job_done_o, err_o, param_ready_o, val_ready_o all = 0 during reset.
  - job_ready_o=1 from the first cycle after reset release.
- Reset mid-job: aborts immediately; no result_valid_o or job_done_o pulses afterwards.
- Command word is driven exactly one cycle after the final parameter accept.
- First Exec cycle is Cmd+1+NumParams.
- First result_valid_o: ResultLatency+1 cycles after the first Exec cycle.
- Results then arrive every 2 cycles.
- job_done_o: ResultLatency cycles after the last Drain cycle, plus one cycle.
- Back-to-back jobs: job_start_i may be accepted the cycle after job_done_o.

## Structure
- tiny_nn_pkg:
  - Already holds CmdOpConvolve, FPStdNaN, fp_t.
  - Add IdleWord, the driver state_e enum and the DrainCycles default.
- One sub-module, tiny_nn_result_capture: delay line plus lo/hi pairing, result_o/result_valid_o generation and the empty flag.
- Parameter register file and FSM stay in the top.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles mid-Load → all outputs at reset values; job_ready_o=1 the cycle after release.
- Basic job:
  - Params 16'h3f80..16'h3f87, then 4 values with val_last_i on the 4th.
  - Expect tnn_data_o sequence: 16'h1000-style command word, the 8 params, the 4 values, 16'h7fc0 (FPStdNaN), 5×16'h0000.
  - Expect floor(10/2)=5 results; job_done_o once.
- Result pairing: model echoes bytes 0x11,0x22,0x33,0x44 at the delayed window → result_o 16'h2211 then 16'h4433.
- Param stall: param_valid_i toggling 1/0 → command word appears only after the 8th accept; Params phase has no gaps.
- Underflow: val_valid_i low on the 3rd Exec cycle → FPStdNaN on that cycle, no Term cycle, err_o=1 until the next job accept, job still completes with job_done_o.
- Odd window: 3 values (window 9) → 4 results; final lo byte dropped; back-to-back second job accepted the cycle after job_done_o.
